// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path and the future receive path:
//   - FSM state encodings and the enumerated state type
//   - parity mode constants
//   - parity helper used when a word is loaded into the shifter
// -----------------------------------------------------------------------------
package uart_pkg;

    // FSM encodings. Values 5..7 are unused and recover to IDLE.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } tx_state_t;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Widest supported data word. Narrower words are zero-extended before
    // calling parity_bit, which leaves the XOR reduction unchanged.
    localparam int MAX_DATA_BITS = 9;

    // Even parity makes the total count of ones even (bit = ^data);
    // odd parity makes it odd (bit = ~^data).
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input int                       mode);
        if (mode == PAR_ODD) begin
            return ~^data;
        end
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_if
// Valid/ready word handshake between a system-side producer and the UART
// transmitter.
//   data_i  : word to transmit (DATA_BITS wide)
//   valid_i : data_i valid
//   ready_o : transmitter can accept; transfer on valid_i && ready_o
// Modports: master = producer side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_i;
    logic                 valid_i;
    logic                 ready_o;

    modport master (output data_i, output valid_i, input  ready_o);
    modport slave  (input  data_i, input  valid_i, output ready_o);

endinterface

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with first-word-fall-through read: o_rd_data always shows
// the head entry, so a consumer can use the word on the same edge it pops.
// Ports:
//   clk, srst   : clock, synchronous active-high reset (empties the FIFO)
//   i_push      : write i_wr_data (ignored while full, even if popping)
//   i_wr_data   : data to write
//   i_pop       : remove head entry (ignored while empty)
//   o_rd_data   : head entry
//   o_full      : level == DEPTH
//   o_empty     : level == 0
//   o_level     : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    logic w_push_ok;
    logic w_pop_ok;

    // Full/empty come from the registered level only, so a pop in the same
    // cycle never frees space for a push.
    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage has no reset; stale contents are unreachable once the
    // pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// Parametrised UART transmitter with an input FIFO. Frames are
// start(0), DATA_BITS data bits LSB first, optional parity, STOP_BITS stop
// bits(1). Consecutive queued words are sent with no idle gap.
// Ports:
//   clk      : system clock
//   reset    : synchronous active-high reset; aborts any frame, empties FIFO
//   bus      : valid/ready word input (slave side of uart_tx_frame_if)
//   serial_o : UART line, idles high
//   active_o : high from start bit through last stop bit
//   done_o   : one-cycle pulse at the end of each frame's final stop bit
//   level_o  : FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 16,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_tx_frame_if.slave              bus,
    output logic                        serial_o,
    output logic                        active_o,
    output logic                        done_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o
);

    // The bit timer also times the whole stop period in one load, so it is
    // sized for STOP_BITS*CLOCKS_PER_BIT-1.
    localparam int            CW        = $clog2(STOP_BITS * CLOCKS_PER_BIT);
    localparam int            IW        = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_BITS * CLOCKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

    // FIFO side
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [DATA_BITS-1:0] w_fifo_data;

    // FSM state and datapath registers, with their next values
    tx_state_t            r_state,   w_state_next;
    logic [CW-1:0]        r_cnt,     w_cnt_next;
    logic [IW-1:0]        r_bit_idx, w_bit_idx_next;
    logic [DATA_BITS-1:0] r_shift,   w_shift_next;
    logic                 r_parity,  w_parity_next;
    logic                 r_serial,  w_serial_next;
    logic                 r_active,  w_active_next;
    logic                 r_done,    w_done_next;

    logic                 w_cnt_zero;
    logic                 w_load_parity;

    // ready is held low during reset so nothing is accepted until the
    // cycle after reset deasserts.
    assign bus.ready_o = !w_full && !reset;
    assign w_push      = bus.valid_i && bus.ready_o;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (reset),
        .i_push    (w_push),
        .i_wr_data (bus.data_i),
        .i_pop     (w_pop),
        .o_rd_data (w_fifo_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (level_o)
    );

    assign w_cnt_zero    = (r_cnt == '0);
    assign w_load_parity = parity_bit(MAX_DATA_BITS'(w_fifo_data), PARITY);

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_serial_next  = r_serial;
        w_active_next  = r_active;
        w_done_next    = 1'b0;
        w_pop          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_serial_next = 1'b1;
                w_active_next = 1'b0;
                if (!w_empty) begin
                    // Pop and drive the start bit on the same edge.
                    w_pop         = 1'b1;
                    w_shift_next  = w_fifo_data;
                    w_parity_next = w_load_parity;
                    w_serial_next = 1'b0;
                    w_active_next = 1'b1;
                    w_cnt_next    = BIT_LOAD;
                    w_state_next  = S_START;
                end
            end

            S_START: begin
                if (w_cnt_zero) begin
                    w_state_next   = S_DATA;
                    w_serial_next  = r_shift[0];
                    w_bit_idx_next = '0;
                    w_cnt_next     = BIT_LOAD;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end

            S_DATA: begin
                if (w_cnt_zero) begin
                    if (r_bit_idx == LAST_BIT) begin
                        if (PARITY != PAR_NONE) begin
                            w_state_next  = S_PARITY;
                            w_serial_next = r_parity;
                            w_cnt_next    = BIT_LOAD;
                        end else begin
                            w_state_next  = S_STOP;
                            w_serial_next = 1'b1;
                            w_cnt_next    = STOP_LOAD;
                        end
                    end else begin
                        // r_shift[0] is on the line; bit 1 goes next.
                        w_shift_next   = r_shift >> 1;
                        w_serial_next  = r_shift[1];
                        w_bit_idx_next = r_bit_idx + IW'(1);
                        w_cnt_next     = BIT_LOAD;
                    end
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end

            S_PARITY: begin
                if (w_cnt_zero) begin
                    w_state_next  = S_STOP;
                    w_serial_next = 1'b1;
                    w_cnt_next    = STOP_LOAD;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end

            S_STOP: begin
                if (w_cnt_zero) begin
                    w_done_next = 1'b1;
                    if (!w_empty) begin
                        // Chain straight into the next frame, no idle bit.
                        w_pop         = 1'b1;
                        w_shift_next  = w_fifo_data;
                        w_parity_next = w_load_parity;
                        w_serial_next = 1'b0;
                        w_active_next = 1'b1;
                        w_cnt_next    = BIT_LOAD;
                        w_state_next  = S_START;
                    end else begin
                        w_serial_next = 1'b1;
                        w_active_next = 1'b0;
                        w_state_next  = S_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end

            default: begin
                w_state_next  = S_IDLE;
                w_serial_next = 1'b1;
                w_active_next = 1'b0;
                w_cnt_next    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_serial  <= 1'b1;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            r_serial  <= w_serial_next;
            r_active  <= w_active_next;
            r_done    <= w_done_next;
        end
    end

    assign serial_o = r_serial;
    assign active_o = r_active;
    assign done_o   = r_done;

endmodule
